cpu_execution_muldiv: RTL

- Multi-cycle multiply/divide execution unit that sits beside the combinational ALU/shifter execution stage.
- Implements the MIPS HI/LO group: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
- Data width is parametrised. Uses iterative radix-2 shift-add multiply and restoring divide, controlled by a start/busy/done handshake with a flush input for pipeline squash.

---
 rtl/cpu_execution_muldiv_if.sv | 27 ++
 rtl/cpu_execution_muldiv.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_execution_muldiv_if.sv
// Handshake and data bundle between the pipeline and the HI/LO multiply/divide unit.
interface cpu_execution_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;
  logic             badfunct;

  modport master (
    output start, funct, op1, op2, flush,
    input  busy, done, result, hi, lo, div_by_zero, badfunct
  );

  modport slave (
    input  start, funct, op1, op2, flush,
    output busy, done, result, hi, lo, div_by_zero, badfunct
  );
endinterface

// File: rtl/cpu_execution_muldiv.sv
// Iterative MIPS HI/LO unit: radix-2 shift-add multiply, restoring divide,
// MFHI/MFLO/MTHI/MTLO, with start/busy/done handshake and flush squash.
module cpu_execution_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cpu_execution_muldiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIN
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [5:0]         funct_q, funct_d;
  logic               negp_q, negp_d;
  logic               negr_q, negr_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               dbz_q, dbz_d;
  logic               bad_q, bad_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               sgn_c;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  // acc_q holds {partial product, remaining multiplier} or {remainder, dividend/quotient}.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, b_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    funct_d  = funct_q;
    negp_d   = negp_q;
    negr_d   = negr_q;
    done_d   = 1'b0;
    result_d = '0;
    dbz_d    = 1'b0;
    bad_d    = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    sgn_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          funct_d = bus.funct;
          negp_d  = 1'b0;
          negr_d  = 1'b0;
          case (bus.funct)
            F_MULT, F_MULTU: begin
              sgn_c   = (bus.funct == F_MULT);
              b_d     = mag(bus.op1, sgn_c);
              acc_d   = {{WIDTH{1'b0}}, mag(bus.op2, sgn_c)};
              negp_d  = sgn_c & (bus.op1[WIDTH-1] ^ bus.op2[WIDTH-1]);
              cnt_d   = CW'(WIDTH);
              state_d = ST_MUL;
            end
            F_DIV, F_DIVU: begin
              sgn_c = (bus.funct == F_DIV);
              if (bus.op2 == '0) begin
                // b_q == 0 marks the divide-by-zero case for the FIN cycle
                b_d     = '0;
                state_d = ST_FIN;
              end else begin
                b_d     = mag(bus.op2, sgn_c);
                acc_d   = {{WIDTH{1'b0}}, mag(bus.op1, sgn_c)};
                negp_d  = sgn_c & (bus.op1[WIDTH-1] ^ bus.op2[WIDTH-1]);
                negr_d  = sgn_c & bus.op1[WIDTH-1];
                cnt_d   = CW'(WIDTH);
                state_d = ST_DIV;
              end
            end
            default: begin
              b_d     = bus.op1;
              state_d = ST_FIN;
            end
          endcase
        end
      end

      ST_MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = ST_FIN;
      end

      ST_DIV: begin
        if (!div_trial[WIDTH]) acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else                   acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = ST_FIN;
      end

      ST_FIN: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        case (funct_q)
          F_MFHI: result_d = hi_q;
          F_MFLO: result_d = lo_q;
          F_MTHI: hi_d = b_q;
          F_MTLO: lo_d = b_q;
          F_MULT, F_MULTU: {hi_d, lo_d} = negp_q ? -acc_q : acc_q;
          F_DIV, F_DIVU: begin
            if (b_q == '0) begin
              dbz_d = 1'b1;
            end else begin
              lo_d = negp_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
              hi_d = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            end
          end
          default: bad_d = 1'b1;
        endcase
      end

      default: state_d = ST_IDLE;
    endcase

    if (bus.flush) begin
      state_d  = ST_IDLE;
      done_d   = 1'b0;
      result_d = '0;
      dbz_d    = 1'b0;
      bad_d    = 1'b0;
      hi_d     = hi_q;
      lo_d     = lo_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      funct_q  <= '0;
      negp_q   <= 1'b0;
      negr_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
      bad_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      funct_q  <= funct_d;
      negp_q   <= negp_d;
      negr_q   <= negr_d;
      done_q   <= done_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
      bad_q    <= bad_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.busy        = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.badfunct    = bad_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule
